// File: rtl/change_dispenser.sv
// Change-return transmitter: dispenses an amount as greedy 10/5/2/1 NIS coins over a valid/ready link.
// Optional per-denomination inventory limits are built when CHANGE_INVENTORY_EN is defined.
module change_dispenser #(
    parameter int AMT_W   = 5,
    parameter int INV_W   = 4,
    parameter int INIT_10 = 4,
    parameter int INIT_5  = 4,
    parameter int INIT_2  = 4,
    parameter int INIT_1  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [3:0]       coin,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AMT_W-1:0] remaining,
    output logic [2:0]       dbg_state
);

    // Coin link: a transfer happens on a rising edge where coin_valid and coin_ready are both 1;
    // coin_valid/coin stay stable until then, and coin_ready is ignored while no coin is offered.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_OFFER  = 3'd2,
        S_FINISH = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [3:0]       coin_q, coin_d;
    logic             coin_valid_q, coin_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             av10, av5, av2, av1;
    logic [3:0]       pick;
    logic             transfer;

    assign transfer = (state_q == S_OFFER) && coin_ready;

`ifdef CHANGE_INVENTORY_EN
    logic [INV_W-1:0] inv10_q, inv5_q, inv2_q, inv1_q;
    logic             error_q, error_d;

    assign av10 = (inv10_q != '0);
    assign av5  = (inv5_q  != '0);
    assign av2  = (inv2_q  != '0);
    assign av1  = (inv1_q  != '0);

    // A coin is only ever offered when its counter is non-zero, so these cannot underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv10_q <= INV_W'(INIT_10);
            inv5_q  <= INV_W'(INIT_5);
            inv2_q  <= INV_W'(INIT_2);
            inv1_q  <= INV_W'(INIT_1);
        end else if (transfer) begin
            case (coin_q)
                4'd10:   inv10_q <= inv10_q - INV_W'(1);
                4'd5:    inv5_q  <= inv5_q  - INV_W'(1);
                4'd2:    inv2_q  <= inv2_q  - INV_W'(1);
                4'd1:    inv1_q  <= inv1_q  - INV_W'(1);
                default: ;
            endcase
        end
    end

    assign error_d = (state_d == S_FAIL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) error_q <= 1'b0;
        else        error_q <= error_d;
    end

    assign error = error_q;
`else
    logic unused_cfg;

    assign av10 = 1'b1;
    assign av5  = 1'b1;
    assign av2  = 1'b1;
    assign av1  = 1'b1;
    assign unused_cfg = ^{INV_W, INIT_10, INIT_5, INIT_2, INIT_1};
    assign error = 1'b0;
`endif

    // Largest available denomination that still fits; 0 means nothing qualifies.
    always_comb begin
        pick = 4'd0;
        if (remaining_q >= AMT_W'(10) && av10)     pick = 4'd10;
        else if (remaining_q >= AMT_W'(5) && av5)  pick = 4'd5;
        else if (remaining_q >= AMT_W'(2) && av2)  pick = 4'd2;
        else if (remaining_q >= AMT_W'(1) && av1)  pick = 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SELECT;
            S_SELECT: begin
                if (remaining_q == '0)  state_d = S_FINISH;
                else if (pick != 4'd0)  state_d = S_OFFER;
                else                    state_d = S_FAIL;
            end
            S_OFFER:  if (coin_ready) state_d = S_SELECT;
            S_FINISH: state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every output appears with its state.
    always_comb begin
        remaining_d  = remaining_q;
        coin_d       = coin_q;
        coin_valid_d = (state_d == S_OFFER);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_FINISH) || (state_d == S_FAIL);
        case (state_q)
            S_IDLE:   if (start) remaining_d = amount;
            S_SELECT: coin_d = (state_d == S_OFFER) ? pick : 4'd0;
            S_OFFER: begin
                if (coin_ready) begin
                    remaining_d = remaining_q - AMT_W'(coin_q);
                    coin_d      = 4'd0;
                end
            end
            default:  coin_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q  <= '0;
            coin_q       <= 4'd0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            remaining_q  <= remaining_d;
            coin_q       <= coin_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin       = coin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign remaining  = remaining_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: greedy change model with optional inventory
// (follows CHANGE_INVENTORY_EN), directed cases plus randomized amounts and backpressure.
module tb_change_dispenser;

    localparam int AMT_W   = 5;
    localparam int INV_W   = 4;
    localparam int INIT_10 = 1;
    localparam int INIT_5  = 0;
    localparam int INIT_2  = 4;
    localparam int INIT_1  = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             coin_ready;
    logic             coin_valid;
    logic [3:0]       coin;
    logic             busy;
    logic             done;
    logic             error;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    // scoreboard
    logic [3:0] exp_q[$];
    int         exp_rem;
    int         exp_err;
    int         inv_m[4];
    int         denoms[4] = '{10, 5, 2, 1};
    int         acc_total;
    int         valid_cycles;

    // ready driver control: 0 always 1, 1 random, 2 stall first offer, 3 hold 0
    int ready_mode = 0;
    int stall_cnt  = 0;

    change_dispenser #(
        .AMT_W(AMT_W), .INV_W(INV_W),
        .INIT_10(INIT_10), .INIT_5(INIT_5), .INIT_2(INIT_2), .INIT_1(INIT_1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
        .coin_ready(coin_ready), .coin_valid(coin_valid), .coin(coin),
        .busy(busy), .done(done), .error(error), .remaining(remaining),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic reload_model();
        for (int i = 0; i < 4; i++) begin
`ifdef CHANGE_INVENTORY_EN
            inv_m[i] = (i == 0) ? INIT_10 : (i == 1) ? INIT_5 : (i == 2) ? INIT_2 : INIT_1;
`else
            inv_m[i] = 1000;
`endif
        end
        exp_q.delete();
    endtask

    // Greedy change from plain arithmetic: take each denomination as often as it fits and stock allows.
    task automatic model_request(input int amt);
        int rem;
        rem = amt;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            while (rem >= denoms[i] && inv_m[i] > 0) begin
                exp_q.push_back(4'(denoms[i]));
                rem -= denoms[i];
`ifdef CHANGE_INVENTORY_EN
                inv_m[i]--;
`endif
            end
        end
        exp_rem = rem;
        exp_err = (rem != 0) ? 1 : 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        amount = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_coin_valid", coin_valid, 0);
        check("rst_coin", coin, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_remaining", remaining, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        reload_model();
    endtask

    // Issues one request and follows it to its done pulse; timed=1 expects done after edge E+2N+1.
    task automatic run_request(input int amt, input bit timed, input bit poke);
        int  n;
        int  k;
        bit  seen;
        @(negedge clk);
        model_request(amt);
        n = exp_q.size();
        acc_total = 0;
        valid_cycles = 0;
        start = 1'b1;
        amount = AMT_W'(amt);
        @(posedge clk);
        #1;
        start = 1'b0;
        amount = AMT_W'($urandom_range(0, 31));
        check("busy_after_start", busy, 1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 400) begin
            @(negedge clk);
            if (poke && k == 3) begin
                start = 1'b1;
                amount = AMT_W'(9);
            end else if (poke && k == 4) begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
            else k++;
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_error", error, exp_err);
            check("done_remaining", remaining, exp_rem);
            check("busy_at_done", busy, 1);
            check("coins_left", exp_q.size(), 0);
            check("acc_total", acc_total, amt - exp_rem);
            if (timed) begin
                check("done_latency", k, 2 * n + 1);
                check("offer_cycles", valid_cycles, n);
            end
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("error_one_cycle", error, 0);
            check("idle_not_busy", busy, 0);
            check("remaining_hold", remaining, exp_rem);
        end
    endtask

    // ready driver
    initial begin
        coin_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: coin_ready = 1'b1;
                1: coin_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (coin_valid && stall_cnt > 0) begin
                        coin_ready = 1'b0;
                        stall_cnt--;
                    end else begin
                        coin_ready = 1'b1;
                    end
                end
                default: coin_ready = 1'b0;
            endcase
        end
    end

    // monitor: coin order, hold-while-stalled, idle coin value
    initial begin
        bit         prev_stall;
        logic [3:0] prev_coin;
        prev_stall = 1'b0;
        prev_coin = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", coin_valid, 1);
                    check("hold_coin", coin, prev_coin);
                end
                if (!coin_valid) begin
                    check("idle_coin_zero", coin, 0);
                end else begin
                    valid_cycles++;
                    check("valid_busy", busy, 1);
                    if (coin_ready) begin
                        if (exp_q.size() == 0) check("extra_coin", coin, 0);
                        else check("coin_seq", coin, exp_q.pop_front());
                        acc_total += int'(coin);
                    end
                end
                prev_stall = coin_valid && !coin_ready;
                prev_coin = coin;
            end
        end
    end

    // main sequence
    initial begin
        bit seen_v;
        rst_n = 1'b0;
        start = 1'b0;
        amount = '0;
        reload_model();
        apply_reset();

        ready_mode = 0;
        run_request(18, 1'b1, 1'b0);

        apply_reset();
        ready_mode = 2;
        stall_cnt = 3;
        run_request(7, 1'b0, 1'b0);
`ifndef CHANGE_INVENTORY_EN
        check("backpressure_offer_cycles", valid_cycles, 5);
`endif

        ready_mode = 0;
        run_request(0, 1'b1, 1'b0);
        check("zero_no_coin", valid_cycles, 0);

        apply_reset();
        ready_mode = 1;
        run_request(18, 1'b0, 1'b1);

        apply_reset();
        ready_mode = 0;
        run_request(25, 1'b1, 1'b0);

        // reset while a coin is offered and stalled
        apply_reset();
        ready_mode = 3;
        @(negedge clk);
        model_request(15);
        start = 1'b1;
        amount = AMT_W'(15);
        @(posedge clk);
        #1 start = 1'b0;
        seen_v = 1'b0;
        for (int i = 0; i < 10 && !seen_v; i++) begin
            @(negedge clk);
            if (coin_valid) seen_v = 1'b1;
        end
        check("mid_offer_seen", seen_v, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", coin_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_remaining", remaining, 0);
        check("mid_rst_coin", coin, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        reload_model();
        ready_mode = 0;
        run_request(5, 1'b1, 1'b0);
        check("loopback_total", acc_total, 5);

        // randomized requests with periodic reset to refill stock
        for (int r = 0; r < 40; r++) begin
            int amt;
            int mode;
            if (r % 5 == 0) apply_reset();
            amt = $urandom_range(0, 31);
            mode = $urandom_range(0, 1);
            ready_mode = mode;
            run_request(amt, (mode == 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
